mdr_mem_seq: RTL and testbench

- Memory-access sequencer for the 16-bit microcontroller datapath.
- Arbitrates the single MAR/MDR/memory path between the instruction-fetch requester and the data (load/store) requester.
- For the granted access it latches the address and store data, runs the memory read/write handshake with a wait-state timeout, and strobes MDR load from memory.
- For reads, it then asserts MDR_En so the MDR output stage drives the internal bus for exactly one cycle.

---
 rtl/mdr_mem_seq.sv | 169 ++++++++++++++++
 tb/tb_mdr_mem_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_mem_seq.sv
// mdr_mem_seq: arbitrates the single MAR/MDR/memory path between the fetch and data requesters.
// Latency: gnt is 1 cycle after the request. From gnt: read done at +3, write done at +2, plus 1 per wait state.
// Backpressure: requests are sampled only in IDLE and must be held until gnt; memory stalls via mem_ready.
//
// Ports:
//   clk, rst                    - clock and synchronous active-high reset
//   if_req, if_addr             - fetch read requester
//   d_req, d_we, d_addr,        - data load/store requester
//   d_wdata
//   gnt_if, gnt_d               - one-cycle grant pulses
//   done, done_src, err         - completion pulse, its source (0 fetch, 1 data) and timeout flag
//   mar_out, mdr_wdata          - registered address and store data to memory
//   mem_rd, mem_wr, mem_ready   - memory handshake
//   mdr_ld                      - load MDR from memory read data (combinational)
//   MDR_En                      - MDR drives the internal bus for one cycle
module mdr_mem_seq #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int WAIT_MAX = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              gnt_if,
  output logic              gnt_d,
  output logic              done,
  output logic              done_src,
  output logic              err,
  output logic [ADDR_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic              mdr_ld,
  output logic              MDR_En
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ACCESS,
    S_XFER,
    S_DONE
  } state_t;

  // Value the wait counter holds during the last ACCESS cycle allowed.
  localparam logic [7:0] LP_CNT_LAST = 8'(WAIT_MAX - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_we_lat;
  logic                r_err;
  logic                r_last_d;   // 1 when the data requester won the last grant
  logic                r_src;
  logic [7:0]          r_cnt;
  logic [ADDR_W-1:0]   r_mar;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_any_req;
  logic                w_pick_d;
  logic                w_timeout;

  always_comb begin
    w_any_req = if_req | d_req;
    // Data wins when it is alone, or when both ask and fetch was not the loser last time.
    w_pick_d  = d_req & ~(if_req & r_last_d);
    // A ready on the final allowed cycle still counts as success.
    w_timeout = (r_cnt == LP_CNT_LAST) & ~mem_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_next = S_GRANT;
        end
      end
      S_GRANT: begin
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (mem_ready) begin
          w_next = r_we_lat ? S_DONE : S_XFER;
        end else if (w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_XFER: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Access context is captured when the request is accepted, so requester
  // inputs may change freely while the access runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we_lat <= 1'b0;
      r_err    <= 1'b0;
      r_last_d <= 1'b1;
      r_src    <= 1'b0;
      r_cnt    <= 8'd0;
      r_mar    <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_src    <= w_pick_d;
            r_last_d <= w_pick_d;
            r_mar    <= w_pick_d ? d_addr : if_addr;
            r_we_lat <= w_pick_d & d_we;
            r_cnt    <= 8'd0;
            r_err    <= 1'b0;
            if (w_pick_d) begin
              r_wdata <= d_wdata;
            end
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        S_DONE: begin
          r_err <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    gnt_if    = (r_state == S_GRANT) & ~r_src;
    gnt_d     = (r_state == S_GRANT) & r_src;
    done      = (r_state == S_DONE);
    err       = (r_state == S_DONE) & r_err;
    done_src  = r_src;
    mar_out   = r_mar;
    mdr_wdata = r_wdata;
    mem_rd    = (r_state == S_ACCESS) & ~r_we_lat;
    mem_wr    = (r_state == S_ACCESS) & r_we_lat;
    mdr_ld    = (r_state == S_ACCESS) & ~r_we_lat & mem_ready;
    MDR_En    = (r_state == S_XFER);
  end

endmodule

// File: tb/tb_mdr_mem_seq.sv
// tb_mdr_mem_seq: self-checking bench for mdr_mem_seq.
// A memory responder raises mem_ready after a per-access number of wait states.
// Accesses come from a vector table; expected results go through a scoreboard queue.
module tb_mdr_mem_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        gnt_if, gnt_d, done, done_src, err;
  logic [15:0] mar_out, mdr_wdata;
  logic        mem_rd, mem_wr;
  logic        mem_ready = 1'b0;
  logic        mdr_ld, MDR_En;

  mdr_mem_seq #(.DATA_W(16), .ADDR_W(16), .WAIT_MAX(7)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .gnt_if(gnt_if), .gnt_d(gnt_d), .done(done), .done_src(done_src), .err(err),
    .mar_out(mar_out), .mdr_wdata(mdr_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready),
    .mdr_ld(mdr_ld), .MDR_En(MDR_En)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        src;    // 0 fetch, 1 data
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          ws;     // wait states before mem_ready; 255 = never ready
    logic        err;
    int          lat;    // cycles from gnt to done
    int          rd;     // expected mem_rd cycles
    int          wr;
    int          ld;
    int          en;
  } vec_t;

  vec_t vecs[8];
  vec_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cur_ws  = 0;
  int acc_cnt = 0;
  int rd_cnt = 0, wr_cnt = 0, ld_cnt = 0, en_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: counts ACCESS cycles and raises mem_ready on cycle ws+1.
  always @(posedge clk) begin
    #1;
    if (mem_rd || mem_wr) begin
      acc_cnt   = acc_cnt + 1;
      mem_ready = (acc_cnt == cur_ws + 1);
    end else begin
      acc_cnt   = 0;
      mem_ready = 1'b0;
    end
  end

  // Strobe counters and exclusivity invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) rd_cnt++;
      if (mem_wr) wr_cnt++;
      if (mdr_ld) ld_cnt++;
      if (MDR_En) en_cnt++;
      chk("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
      chk("ld_en_excl", 32'(mdr_ld & MDR_En), 32'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},   32'({gnt_if, gnt_d}), 32'd0);
    chk({tag, "_done"},  32'({done, err}), 32'd0);
    chk({tag, "_mem"},   32'({mem_rd, mem_wr}), 32'd0);
    chk({tag, "_mdr"},   32'({mdr_ld, MDR_En}), 32'd0);
    chk({tag, "_mar"},   32'(mar_out), 32'd0);
    chk({tag, "_wdata"}, 32'(mdr_wdata), 32'd0);
    chk({tag, "_src"},   32'(done_src), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, output int gw);
    int   lat;
    logic got;
    vec_t e;
    cur_ws = v.ws;
    if (v.src) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    gw  = 0;
    got = 1'b0;
    while (!got && gw < 20) begin
      @(negedge clk);
      gw++;
      if (gnt_if || gnt_d) got = 1'b1;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    chk("gnt_seen", 32'(got), 32'd1);
    if (got) begin
      chk("gnt_src", 32'({gnt_d, gnt_if}), v.src ? 32'd2 : 32'd1);
      chk("mar_out", 32'(mar_out), 32'(v.addr));
      if (v.src && v.we) chk("mdr_wdata", 32'(mdr_wdata), 32'(v.wdata));
      sb_q.push_back(v);
      rd_cnt = 0; wr_cnt = 0; ld_cnt = 0; en_cnt = 0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 300) begin
        @(negedge clk);
        lat++;
        if (done) got = 1'b1;
      end
      chk("done_seen", 32'(got), 32'd1);
      e = sb_q.pop_front();
      if (got) begin
        chk("done_src", 32'(done_src), 32'(e.src));
        chk("err",      32'(err), 32'(e.err));
        chk("latency",  32'(lat), 32'(e.lat));
        chk("rd_cycles", 32'(rd_cnt), 32'(e.rd));
        chk("wr_cycles", 32'(wr_cnt), 32'(e.wr));
        chk("ld_pulses", 32'(ld_cnt), 32'(e.ld));
        chk("en_pulses", 32'(en_cnt), 32'(e.en));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int   gw;
    int   cyc;
    int   ng;
    int   last_done;
    int   nd;
    logic gs[4];
    vec_t v;

    //           src   we    addr      wdata     ws   err   lat rd wr ld en
    vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 0,   1'b0, 3,  1, 0, 1, 1};
    vecs[1] = '{1'b1, 1'b1, 16'h1234, 16'h00AD, 2,   1'b0, 4,  0, 3, 0, 0};
    vecs[2] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 255, 1'b1, 8,  7, 0, 0, 0};
    vecs[3] = '{1'b0, 1'b0, 16'h0042, 16'h0000, 0,   1'b0, 3,  1, 0, 1, 1};
    vecs[4] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 6,   1'b0, 9,  7, 0, 1, 1};
    vecs[5] = '{1'b1, 1'b1, 16'h0400, 16'h5A5A, 0,   1'b0, 2,  0, 1, 0, 0};
    vecs[6] = '{1'b0, 1'b0, 16'h0044, 16'h0000, 3,   1'b0, 6,  4, 0, 1, 1};
    vecs[7] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 1,   1'b0, 4,  2, 0, 1, 1};

    // Reset values.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");

    // Contention: both requesters held; grants alternate, fetch first.
    rst = 1'b0;
    if_req = 1'b1; if_addr = 16'h0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200; d_wdata = 16'hBEEF;
    cur_ws = 0;
    cyc = 0; ng = 0; last_done = 0;
    while (ng < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done) last_done = cyc;
      if (gnt_if || gnt_d) begin
        gs[ng] = gnt_d;
        chk("rr_mar", 32'(mar_out), gnt_d ? 32'h0200 : 32'h0100);
        if (ng > 0) chk("rr_idle_gap", 32'(cyc - last_done), 32'd2);
        ng++;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    chk("rr_grants", 32'(ng), 32'd4);
    for (int k = 0; k < ng; k++) chk("rr_order", 32'(gs[k]), 32'(k % 2));
    nd = 0;
    while (!done && nd < 20) begin
      @(negedge clk);
      nd++;
    end
    chk("rr_last_done", 32'(done), 32'd1);

    // Reset again; fetch issued as reset drops must be granted one cycle later.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst1");
    rst = 1'b0;
    run_vec(vecs[0], gw);
    chk("first_gnt_cycle", 32'(gw), 32'd1);

    // Table vectors: store with wait states, timeout, recovery, boundary, mixes.
    for (int i = 1; i < 8; i++) begin
      run_vec(vecs[i], gw);
    end

    // Reset during the 2nd ACCESS cycle of a read.
    @(negedge clk);
    cur_ws = 255;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0ABC;
    nd = 0;
    while (!gnt_d && nd < 20) begin
      @(negedge clk);
      nd++;
    end
    d_req = 1'b0;
    chk("mid_gnt", 32'(gnt_d), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_access2_rd", 32'(mem_rd), 32'd1);
    chk("mid_access2_mar", 32'(mar_out), 32'h0ABC);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_no_done", 32'(nd), 32'd0);
    v = '{1'b1, 1'b0, 16'h0777, 16'h0000, 0, 1'b0, 3, 1, 0, 1, 1};
    run_vec(v, gw);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
